// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving two requesters shared access
// to a single-port memory. Grants are one-cycle pulses issued together with
// the registered memory strobe; read data is steered back by a tag pipeline.
//
// Handshake: rqN_req is a level held (with wr/addr/wdata stable) until the
// requester sees rqN_gnt. The gnt cycle is the cycle the access is on the
// memory port. In that cycle the requester must drop req or present its next
// request. A requester that is being granted this cycle is not eligible, so a
// held req is never granted twice for one access.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rq0_req,
  input  logic              rq0_wr,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq1_req,
  input  logic              rq1_wr,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic              rq0_rvalid,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic [CNT_W-1:0]  contention_cnt
);

  // 1 = requester 1 won the most recent grant; resets to 1 so rq0 wins the first tie
  logic              last_winner;
  logic              elig0;
  logic              elig1;
  logic              tie;
  logic              win0;
  logic              win1;
  logic              win_any;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Tag pipeline: valid bit and requester id per in-flight read
  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_id;

  // Arbitration on the eligible set and selection of the winner's access
  always_comb begin
    elig0     = rq0_req & ~rq0_gnt;
    elig1     = rq1_req & ~rq1_gnt;
    tie       = elig0 & elig1;
    win0      = elig0 & (~elig1 | last_winner);
    win1      = elig1 & (~elig0 | ~last_winner);
    win_any   = win0 | win1;
    win_wr    = rq0_wr;
    win_addr  = rq0_addr;
    win_wdata = rq0_wdata;
    if (win1) begin
      win_wr    = rq1_wr;
      win_addr  = rq1_addr;
      win_wdata = rq1_wdata;
    end
  end

  // Issue the winning access onto the memory port and pulse its grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq0_gnt     <= 1'b0;
      rq1_gnt     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      last_winner <= 1'b1;
    end else begin
      rq0_gnt <= win0;
      rq1_gnt <= win1;
      mem_wr  <= win_any & win_wr;
      mem_rd  <= win_any & ~win_wr;
      if (win_any) begin
        mem_addr    <= win_addr;
        mem_wr_data <= win_wdata;
        last_winner <= win1;
      end
    end
  end

  // Saturating count of cycles where both requesters competed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_cnt <= '0;
    end else if (tie && (contention_cnt != {CNT_W{1'b1}})) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

  // Read tag pipeline; stage 0 is loaded on the same edge as mem_rd, and the
  // rvalid registers act as its final stage, aligned with mem_rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v      <= '0;
      tag_id     <= '0;
      rq0_rvalid <= 1'b0;
      rq1_rvalid <= 1'b0;
    end else begin
      tag_v[0]  <= win_any & ~win_wr;
      tag_id[0] <= win1;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      rq0_rvalid <= tag_v[RD_LATENCY-1] & ~tag_id[RD_LATENCY-1];
      rq1_rvalid <= tag_v[RD_LATENCY-1] & tag_id[RD_LATENCY-1];
    end
  end

  // Busy while any read is between its strobe and its data return
  always_comb begin
    busy = (|tag_v) | rq0_rvalid | rq1_rvalid;
  end

  // Read data is steered by rvalid only; the data path is a pass-through
  always_comb begin
    rq_rdata = mem_rd_data;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances share the requester inputs:
// dut_a (RD_LATENCY=1, CNT_W=4) and dut_b (RD_LATENCY=3, CNT_W=16), each
// with its own memory model. Read returns are scoreboarded per instance.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rq0_req, rq0_wr, rq1_req, rq1_wr;
  logic [8:0]  rq0_addr, rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;

  logic        a_rq0_gnt, a_rq1_gnt, a_rq0_rvalid, a_rq1_rvalid;
  logic [31:0] a_rq_rdata, a_mem_wr_data, a_mem_rd_data;
  logic [8:0]  a_mem_addr;
  logic        a_mem_wr, a_mem_rd, a_busy;
  logic [3:0]  a_cnt;

  logic        b_rq0_gnt, b_rq1_gnt, b_rq0_rvalid, b_rq1_rvalid;
  logic [31:0] b_rq_rdata, b_mem_wr_data, b_mem_rd_data;
  logic [8:0]  b_mem_addr;
  logic        b_mem_wr, b_mem_rd, b_busy;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_a   [512];
  logic [31:0] mem_b   [512];
  logic [31:0] exp_mem [512];
  logic [31:0] a_pipe;
  logic [31:0] b_pipe  [3];
  logic [32:0] exp_a_q [$];
  logic [32:0] exp_b_q [$];
  logic [32:0] ea;
  logic [32:0] eb;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rq0_req(rq0_req), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq1_req(rq1_req), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq0_gnt(a_rq0_gnt), .rq1_gnt(a_rq1_gnt),
    .rq0_rvalid(a_rq0_rvalid), .rq1_rvalid(a_rq1_rvalid), .rq_rdata(a_rq_rdata),
    .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wr_data), .mem_wr(a_mem_wr),
    .mem_rd(a_mem_rd), .mem_rd_data(a_mem_rd_data),
    .busy(a_busy), .contention_cnt(a_cnt)
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rq0_req(rq0_req), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq1_req(rq1_req), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq0_gnt(b_rq0_gnt), .rq1_gnt(b_rq1_gnt),
    .rq0_rvalid(b_rq0_rvalid), .rq1_rvalid(b_rq1_rvalid), .rq_rdata(b_rq_rdata),
    .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data), .mem_wr(b_mem_wr),
    .mem_rd(b_mem_rd), .mem_rd_data(b_mem_rd_data),
    .busy(b_busy), .contention_cnt(b_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: write on strobe, read data appears RD_LATENCY cycles later
  always @(posedge clk) begin
    if (a_mem_wr) mem_a[a_mem_addr] <= a_mem_wr_data;
    a_pipe <= a_mem_rd ? mem_a[a_mem_addr] : 32'hBAD0BAD0;
  end
  assign a_mem_rd_data = a_pipe;

  always @(posedge clk) begin
    if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_wr_data;
    b_pipe[0] <= b_mem_rd ? mem_b[b_mem_addr] : 32'hBAD0BAD0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rd_data = b_pipe[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic id, input logic [8:0] addr);
    exp_a_q.push_back({id, exp_mem[addr]});
    exp_b_q.push_back({id, exp_mem[addr]});
  endtask

  // Scoreboard monitors: every rvalid must match the oldest expected read
  always begin
    @(posedge clk);
    #1;
    if (a_rq0_rvalid || a_rq1_rvalid) begin
      chk("a_rvalid_expected", (exp_a_q.size() != 0), 1);
      if (exp_a_q.size() != 0) begin
        ea = exp_a_q.pop_front();
        chk("a_rvalid_data", {a_rq0_rvalid, a_rq1_rvalid, a_rq_rdata}, {~ea[32], ea[32], ea[31:0]});
      end
    end
    if (b_rq0_rvalid || b_rq1_rvalid) begin
      chk("b_rvalid_expected", (exp_b_q.size() != 0), 1);
      if (exp_b_q.size() != 0) begin
        eb = exp_b_q.pop_front();
        chk("b_rvalid_data", {b_rq0_rvalid, b_rq1_rvalid, b_rq_rdata}, {~eb[32], eb[32], eb[31:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i]   = 32'hA5A50000 | 32'(i);
      mem_b[i]   = 32'hA5A50000 | 32'(i);
      exp_mem[i] = 32'hA5A50000 | 32'(i);
    end
    mem_a[5] = 32'hDEADBEEF;
    mem_b[5] = 32'hDEADBEEF;
    exp_mem[5] = 32'hDEADBEEF;

    // Reset with both requests already held: rq0 writes 0x11 to 0x010, rq1 reads 0x020
    rst_n = 1'b0;
    rq0_req = 1'b1; rq0_wr = 1'b1; rq0_addr = 9'h010; rq0_wdata = 32'h11;
    rq1_req = 1'b1; rq1_wr = 1'b0; rq1_addr = 9'h020; rq1_wdata = 32'h0;
    exp_mem[9'h010] = 32'h11;
    for (int i = 0; i < 3; i++) push_read(1'b1, 9'h020);
    cyc();
    cyc();
    chk("rst_gnt", {a_rq0_gnt, a_rq1_gnt, b_rq0_gnt, b_rq1_gnt}, 0);
    chk("rst_strobes", {a_mem_wr, a_mem_rd, b_mem_wr, b_mem_rd}, 0);
    chk("rst_rvalid", {a_rq0_rvalid, a_rq1_rvalid, b_rq0_rvalid, b_rq1_rvalid}, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wr_data", a_mem_wr_data, 0);
    chk("rst_cnt", {a_cnt, b_cnt}, 0);
    chk("rst_busy", {a_busy, b_busy}, 0);
    rst_n = 1'b1;

    // Held contention: grants alternate rq0, rq1, ... ; only the first cycle is a tie
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("t2_a_gnt", {a_rq0_gnt, a_rq1_gnt}, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_b_gnt", {b_rq0_gnt, b_rq1_gnt}, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_strobes", {a_mem_wr, a_mem_rd}, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_addr", a_mem_addr, (i % 2 == 1) ? 9'h010 : 9'h020);
      if (i % 2 == 1) chk("t2_wdata", a_mem_wr_data, 32'h11);
      chk("t2_cnt", {a_cnt, b_cnt}, {4'd1, 16'd1});
      if (i == 5) rq0_req = 1'b0;
      if (i == 6) rq1_req = 1'b0;
    end
    repeat (5) cyc();
    chk("t2_idle_strobes", {a_mem_wr, a_mem_rd, b_mem_wr, b_mem_rd}, 0);
    chk("t2_addr_hold", a_mem_addr, 9'h020);
    chk("t2_busy_clear", {a_busy, b_busy}, 0);

    // Single uncontested read of 0x005 returning 0xDEADBEEF
    rq0_req = 1'b1; rq0_wr = 1'b0; rq0_addr = 9'h005;
    push_read(1'b0, 9'h005);
    cyc();
    chk("t1_issue", {a_mem_rd, a_mem_wr, a_rq0_gnt, a_rq1_gnt}, 4'b1010);
    chk("t1_addr", a_mem_addr, 9'h005);
    chk("t1_busy_issue", a_busy, 1);
    rq0_req = 1'b0;
    cyc();
    chk("t1_rvalid", {a_rq0_rvalid, a_rq1_rvalid}, 2'b10);
    chk("t1_rdata", a_rq_rdata, 32'hDEADBEEF);
    chk("t1_busy_ret", a_busy, 1);
    chk("t1_no_strobe", a_mem_rd, 0);
    cyc();
    chk("t1_after", {a_rq0_rvalid, a_busy}, 0);
    repeat (3) cyc();

    // Read back the address written under contention
    rq0_req = 1'b1; rq0_wr = 1'b0; rq0_addr = 9'h010;
    push_read(1'b0, 9'h010);
    cyc();
    chk("rb_gnt", a_rq0_gnt, 1);
    rq0_req = 1'b0;
    repeat (5) cyc();

    // Lone rq1 holding req: grants on alternate cycles only
    rq1_req = 1'b1; rq1_wr = 1'b0; rq1_addr = 9'h030;
    for (int i = 0; i < 3; i++) push_read(1'b1, 9'h030);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      chk("t3_gnt1", {a_rq1_gnt, b_rq1_gnt}, (i % 2 == 1 && i < 7) ? 2'b11 : 2'b00);
      chk("t3_gnt0", {a_rq0_gnt, b_rq0_gnt}, 0);
      if (i == 6) rq1_req = 1'b0;
    end
    repeat (5) cyc();

    // Back-to-back reads from both requesters, checked on the 3-cycle instance
    rq0_req = 1'b1; rq0_wr = 1'b0; rq0_addr = 9'h001;
    push_read(1'b0, 9'h001);
    push_read(1'b1, 9'h002);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("t4_mem_rd", b_mem_rd, (k == 1 || k == 2));
      chk("t4_rvalid0", b_rq0_rvalid, (k == 4));
      chk("t4_rvalid1", b_rq1_rvalid, (k == 5));
      chk("t4_busy", b_busy, (k <= 5));
      if (k == 4) chk("t4_rdata0", b_rq_rdata, exp_mem[9'h001]);
      if (k == 5) chk("t4_rdata1", b_rq_rdata, exp_mem[9'h002]);
      if (k == 1) begin
        rq0_req = 1'b0;
        rq1_req = 1'b1; rq1_wr = 1'b0; rq1_addr = 9'h002;
      end
      if (k == 2) rq1_req = 1'b0;
    end
    repeat (3) cyc();

    // Reset asserted asynchronously while a read is in flight
    rq0_req = 1'b1; rq0_wr = 1'b0; rq0_addr = 9'h005;
    cyc();
    chk("t5_strobe", {a_mem_rd, b_mem_rd}, 2'b11);
    chk("t5_cnt_before", {a_cnt, b_cnt}, {4'd1, 16'd1});
    rq0_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_strobes", {a_mem_rd, b_mem_rd, a_mem_wr, b_mem_wr}, 0);
    chk("t5_async_gnt", {a_rq0_gnt, b_rq0_gnt}, 0);
    chk("t5_async_addr", {a_mem_addr, b_mem_addr}, 0);
    chk("t5_async_wdata", a_mem_wr_data, 0);
    chk("t5_async_cnt", {a_cnt, b_cnt}, 0);
    chk("t5_async_busy", {a_busy, b_busy}, 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_no_rvalid", {a_rq0_rvalid, a_rq1_rvalid, b_rq0_rvalid, b_rq1_rvalid}, 0);
      chk("t5_no_strobe", {a_mem_rd, a_mem_wr, b_mem_rd, b_mem_wr}, 0);
    end

    // Twenty tie rounds: 4-bit counter saturates, 16-bit counter keeps counting
    for (int r = 0; r < 20; r++) begin
      rq0_req = 1'b1; rq0_wr = 1'b1; rq0_addr = 9'h040; rq0_wdata = 32'(r);
      rq1_req = 1'b1; rq1_wr = 1'b1; rq1_addr = 9'h041; rq1_wdata = ~32'(r);
      exp_mem[9'h040] = 32'(r);
      exp_mem[9'h041] = ~32'(r);
      cyc();
      chk("t6_first_gnt", {a_rq0_gnt, a_rq1_gnt}, 2'b10);
      chk("t6_a_cnt", a_cnt, (r + 1 > 15) ? 15 : r + 1);
      chk("t6_b_cnt", b_cnt, r + 1);
      rq0_req = 1'b0;
      cyc();
      chk("t6_second_gnt", {a_rq0_gnt, a_rq1_gnt}, 2'b01);
      rq1_req = 1'b0;
      cyc();
    end
    chk("t6_saturated", a_cnt, 4'hF);
    chk("t6_b_total", b_cnt, 16'd20);

    // Written values land in both memory models
    chk("t6_mem_a", {mem_a[9'h040], mem_a[9'h041]}, {exp_mem[9'h040], exp_mem[9'h041]});
    chk("t6_mem_b", {mem_b[9'h040], mem_b[9'h041]}, {exp_mem[9'h040], exp_mem[9'h041]});

    repeat (5) cyc();
    chk("a_q_drained", exp_a_q.size(), 0);
    chk("b_q_drained", exp_b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
